// File: rtl/line_buffer_11x11_pkg.sv
// Constants and helpers shared by the 11-row line buffer and the downstream window buffer.
// The widest supported pixel is MAX_PIX_W bits, which sets the size of the packed column word.
package line_buffer_11x11_pkg;

    localparam int PIX_W     = 8;
    localparam int WIN_N     = 11;
    localparam int LINES     = WIN_N - 1;
    localparam int IDX_W     = 10;
    localparam int MAX_PIX_W = 32;

    typedef logic [LINES*MAX_PIX_W-1:0] col_word_t;

    // Row k of a packed column word. Row 0 is the oldest row, held in the top slice.
    function automatic logic [MAX_PIX_W-1:0] sliceRow(input col_word_t word, input int k, input int pixW);
        col_word_t            shifted;
        logic [MAX_PIX_W-1:0] mask;
        shifted = word >> ((LINES - 1 - k) * pixW);
        mask    = '1;
        mask    = mask >> (MAX_PIX_W - pixW);
        return shifted[MAX_PIX_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/line_buffer_11x11_column_ram.sv
// Single-port column store: asynchronous read, synchronous write.
// A read in the same cycle as a write to that address returns the old word.
module line_column_ram #(
    parameter  int DEPTH  = 640,
    parameter  int WIDTH  = 80,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/line_buffer_11x11.sv
// Streaming line buffer: keeps the last 10 rows per column and presents the 11-pixel vertical
// column for every accepted pixel, one cycle later. DATA_W must not exceed MAX_PIX_W.
module line_buffer_11x11
    import line_buffer_11x11_pkg::*;
#(
    parameter int COLS   = 640,
    parameter int ROWS   = 480,
    parameter int DATA_W = PIX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] S1_o,
    output logic [DATA_W-1:0] S2_o,
    output logic [DATA_W-1:0] S3_o,
    output logic [DATA_W-1:0] S4_o,
    output logic [DATA_W-1:0] S5_o,
    output logic [DATA_W-1:0] S6_o,
    output logic [DATA_W-1:0] S7_o,
    output logic [DATA_W-1:0] S8_o,
    output logic [DATA_W-1:0] S9_o,
    output logic [DATA_W-1:0] S10_o,
    output logic [DATA_W-1:0] S11_o,
    output logic              valid_o,
    output logic [IDX_W-1:0]  col_o,
    output logic [IDX_W-1:0]  row_o,
    output logic              frame_done_o
);

    localparam int WORD_W = LINES * DATA_W;
    localparam int ADDR_W = $clog2(COLS);

    logic [IDX_W-1:0]  colCnt_q, colCnt_d;
    logic [IDX_W-1:0]  rowCnt_q, rowCnt_d;
    logic [IDX_W-1:0]  colOut_q, colOut_d;
    logic [IDX_W-1:0]  rowOut_q, rowOut_d;
    logic              validOut_q, validOut_d;
    logic              frameDone_q, frameDone_d;
    logic [DATA_W-1:0] tap_q [WIN_N];
    logic [DATA_W-1:0] tap_d [WIN_N];

    logic [WORD_W-1:0] rdWord;
    logic [WORD_W-1:0] wrWord;
    logic              wrEn;
    col_word_t         rdWordExt;

    line_column_ram #(
        .DEPTH(COLS),
        .WIDTH(WORD_W)
    ) u_ram (
        .clk_i  (clk),
        .we_i   (wrEn),
        .addr_i (colCnt_q[ADDR_W-1:0]),
        .wdata_i(wrWord),
        .rdata_o(rdWord)
    );

    // A pixel arriving together with reset is dropped, so it must not disturb the store either.
    assign wrEn      = valid_i && !rst;
    assign wrWord    = {rdWord[WORD_W-DATA_W-1:0], data_i};
    assign rdWordExt = col_word_t'(rdWord);

    always_comb begin
        colCnt_d    = colCnt_q;
        rowCnt_d    = rowCnt_q;
        colOut_d    = colOut_q;
        rowOut_d    = rowOut_q;
        validOut_d  = 1'b0;
        frameDone_d = 1'b0;
        tap_d       = tap_q;

        if (valid_i) begin
            for (int k = 0; k < LINES; k++) begin
                tap_d[k] = DATA_W'(sliceRow(rdWordExt, k, DATA_W));
            end
            tap_d[WIN_N-1] = data_i;
            colOut_d       = colCnt_q;
            rowOut_d       = rowCnt_q;
            validOut_d     = (rowCnt_q >= IDX_W'(LINES));
            frameDone_d    = (colCnt_q == IDX_W'(COLS - 1)) && (rowCnt_q == IDX_W'(ROWS - 1));

            if (colCnt_q == IDX_W'(COLS - 1)) begin
                colCnt_d = '0;
                if (rowCnt_q == IDX_W'(ROWS - 1)) begin
                    rowCnt_d = '0;
                end else begin
                    rowCnt_d = rowCnt_q + 1'b1;
                end
            end else begin
                colCnt_d = colCnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            colCnt_q    <= '0;
            rowCnt_q    <= '0;
            colOut_q    <= '0;
            rowOut_q    <= '0;
            validOut_q  <= 1'b0;
            frameDone_q <= 1'b0;
            for (int k = 0; k < WIN_N; k++) begin
                tap_q[k] <= '0;
            end
        end else begin
            colCnt_q    <= colCnt_d;
            rowCnt_q    <= rowCnt_d;
            colOut_q    <= colOut_d;
            rowOut_q    <= rowOut_d;
            validOut_q  <= validOut_d;
            frameDone_q <= frameDone_d;
            tap_q       <= tap_d;
        end
    end

    assign S1_o         = tap_q[0];
    assign S2_o         = tap_q[1];
    assign S3_o         = tap_q[2];
    assign S4_o         = tap_q[3];
    assign S5_o         = tap_q[4];
    assign S6_o         = tap_q[5];
    assign S7_o         = tap_q[6];
    assign S8_o         = tap_q[7];
    assign S9_o         = tap_q[8];
    assign S10_o        = tap_q[9];
    assign S11_o        = tap_q[10];
    assign valid_o      = validOut_q;
    assign col_o        = colOut_q;
    assign row_o        = rowOut_q;
    assign frame_done_o = frameDone_q;

endmodule

// File: tb/tb_line_buffer_11x11.sv
// Bench for line_buffer_11x11 on a 16x16 image: an image-array model predicts every output each
// cycle, and a few hand-computed values pin the model at the first column, gaps and frame end.
module tb_line_buffer_11x11;

    localparam int COLS = 16;
    localparam int ROWS = 16;
    localparam int DW   = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          validIn = 1'b0;
    logic [DW-1:0] dataIn = '0;
    logic [DW-1:0] s1, s2, s3, s4, s5, s6, s7, s8, s9, s10, s11;
    logic          validOut;
    logic          frameDone;
    logic [9:0]    colOut;
    logic [9:0]    rowOut;
    logic [DW-1:0] dutTap [11];

    int errors = 0;
    int checks = 0;
    bit checkEn = 1'b0;

    // Model state: the current frame as an image plus the expected registered outputs.
    logic [DW-1:0] img [ROWS][COLS];
    int            mRow = 0;
    int            mCol = 0;
    logic [DW-1:0] expTap [11];
    bit            expValid = 1'b0;
    bit            expDone = 1'b0;
    bit            tapsKnown = 1'b0;
    int            expCol = 0;
    int            expRow = 0;

    line_buffer_11x11 #(
        .COLS  (COLS),
        .ROWS  (ROWS),
        .DATA_W(DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_i     (validIn),
        .data_i      (dataIn),
        .S1_o        (s1),
        .S2_o        (s2),
        .S3_o        (s3),
        .S4_o        (s4),
        .S5_o        (s5),
        .S6_o        (s6),
        .S7_o        (s7),
        .S8_o        (s8),
        .S9_o        (s9),
        .S10_o       (s10),
        .S11_o       (s11),
        .valid_o     (validOut),
        .col_o       (colOut),
        .row_o       (rowOut),
        .frame_done_o(frameDone)
    );

    assign dutTap[0]  = s1;
    assign dutTap[1]  = s2;
    assign dutTap[2]  = s3;
    assign dutTap[3]  = s4;
    assign dutTap[4]  = s5;
    assign dutTap[5]  = s6;
    assign dutTap[6]  = s7;
    assign dutTap[7]  = s8;
    assign dutTap[8]  = s9;
    assign dutTap[9]  = s10;
    assign dutTap[10] = s11;

    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int r, input int c);
        return DW'(r * 16 + c);
    endfunction

    // Taps for an accepted pixel at (r,c) are rows r-10..r of column c in the current frame.
    task automatic modelStep(input bit r, input bit v, input logic [DW-1:0] d);
        if (r) begin
            mRow = 0;
            mCol = 0;
            for (int k = 0; k < 11; k++) expTap[k] = '0;
            expValid  = 1'b0;
            expDone   = 1'b0;
            expCol    = 0;
            expRow    = 0;
            tapsKnown = 1'b1;
        end else if (v) begin
            img[mRow][mCol] = d;
            expValid  = (mRow >= 10);
            expDone   = (mRow == ROWS - 1) && (mCol == COLS - 1);
            expCol    = mCol;
            expRow    = mRow;
            tapsKnown = expValid;
            if (expValid) begin
                for (int k = 0; k < 10; k++) expTap[k] = img[mRow - 10 + k][mCol];
            end
            expTap[10] = d;
            mCol++;
            if (mCol == COLS) begin
                mCol = 0;
                mRow++;
                if (mRow == ROWS) mRow = 0;
            end
        end else begin
            expValid = 1'b0;
            expDone  = 1'b0;
        end
    endtask

    task automatic applyStimulus(input bit r, input bit v, input logic [DW-1:0] d);
        @(negedge clk);
        rst     = r;
        validIn = v;
        dataIn  = d;
        @(posedge clk);
        modelStep(r, v, d);
    endtask

    task automatic sendPixel(input logic [DW-1:0] d, input int nIdle);
        for (int i = 0; i < nIdle; i++) applyStimulus(1'b0, 1'b0, DW'($urandom));
        applyStimulus(1'b0, 1'b1, d);
    endtask

    function automatic int randomGap();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
    endfunction

    task automatic checkOutput();
        checkVal("valid_o", validOut, expValid);
        checkVal("frame_done_o", frameDone, expDone);
        checkVal("col_o", colOut, expCol);
        checkVal("row_o", rowOut, expRow);
        checkVal("S11_o", dutTap[10], expTap[10]);
        if (tapsKnown) begin
            for (int k = 0; k < 10; k++) checkVal($sformatf("S%0d_o", k + 1), dutTap[k], expTap[k]);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) checkOutput();
    end

    initial begin
        bit stop;

        // Reset held with a pixel offered: the pixel must be dropped.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 8'hAA);
        checkEn = 1'b1;
        #1;
        checkVal("reset valid_o", validOut, 0);
        checkVal("reset frame_done_o", frameDone, 0);
        checkVal("reset S1_o", dutTap[0], 0);
        checkVal("reset S11_o", dutTap[10], 0);

        // Frame A: gap-free through row 10, a 1,0,0,1 gap in row 11, random gaps afterwards.
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                int nIdle;
                if (r <= 10) nIdle = 0;
                else if (r == 11) nIdle = (c == 3) ? 2 : 0;
                else nIdle = randomGap();
                sendPixel(pat(r, c), nIdle);
                if (r == 10 && c == 0) begin
                    #1;
                    for (int k = 0; k < 11; k++)
                        checkVal($sformatf("first column S%0d_o", k + 1), dutTap[k], k * 16);
                    checkVal("first column valid_o", validOut, 1);
                    checkVal("first column row_o", rowOut, 10);
                    checkVal("first column col_o", colOut, 0);
                end
                if (r == 11 && c == 3) begin
                    #1;
                    checkVal("after gap S1_o", dutTap[0], 19);
                    checkVal("after gap S11_o", dutTap[10], 179);
                end
                if (r == 15 && c == 15) begin
                    #1;
                    checkVal("frame end S11_o", dutTap[10], 255);
                    checkVal("frame end S1_o", dutTap[0], 95);
                    checkVal("frame end frame_done_o", frameDone, 1);
                end
            end
        end

        // Frame B: random pixels with random gaps, up to just before (12,5).
        stop = 1'b0;
        for (int r = 0; r < ROWS && !stop; r++) begin
            for (int c = 0; c < COLS && !stop; c++) begin
                if (r == 12 && c == 5) stop = 1'b1;
                else sendPixel(DW'($urandom), randomGap());
            end
        end

        // Mid-frame reset with pixel (12,5) offered alongside it.
        applyStimulus(1'b1, 1'b1, pat(12, 5));
        #1;
        checkVal("mid reset valid_o", validOut, 0);
        checkVal("mid reset S11_o", dutTap[10], 0);
        checkVal("mid reset row_o", rowOut, 0);

        // Restarted stream: first window column must come from the new run only.
        for (int r = 0; r <= 10; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (r < 10 || c < 4) begin
                    sendPixel(pat(r, c), randomGap());
                    if (r == 10 && c == 0) begin
                        #1;
                        checkVal("restart S1_o", dutTap[0], 0);
                        checkVal("restart S6_o", dutTap[5], 80);
                        checkVal("restart S11_o", dutTap[10], 160);
                        checkVal("restart valid_o", validOut, 1);
                    end
                end
            end
        end

        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 8'h00);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
